// File: rtl/bip_control_unit.sv
// BIP I control unit: PC, two-cycle FETCH/EXEC sequencer and opcode decoder.
// Optional BIP_ILLEGAL_TRAP_EN: undefined opcodes halt and raise sticky Illegal.
module bip_control_unit #(
    parameter int PC_WIDTH    = 11,
    parameter int INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Enable,
    output logic [PC_WIDTH-1:0]    Instr_Addr,
    input  logic [INSTR_WIDTH-1:0] Instr,
    output logic [1:0]             SelA,
    output logic                   SelB,
    output logic [PC_WIDTH-1:0]    Addr,
    output logic                   WrAcc,
    output logic                   Op,
    output logic                   WrRam,
    output logic                   RdRam,
`ifdef BIP_ILLEGAL_TRAP_EN
    output logic                   Illegal,
`endif
    output logic                   Halted
);

    localparam int OPC_W = INSTR_WIDTH - PC_WIDTH;

    localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(7);

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  illegal_q, illegal_d;
    logic                  stop;
    logic [OPC_W-1:0]      opcode;
    logic [PC_WIDTH-1:0]   operand;

    assign opcode  = Instr[INSTR_WIDTH-1:PC_WIDTH];
    assign operand = Instr[PC_WIDTH-1:0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        illegal_d = illegal_q;
        stop      = 1'b0;
        SelA      = 2'd0;
        SelB      = 1'b0;
        Addr      = '0;
        WrAcc     = 1'b0;
        Op        = 1'b0;
        WrRam     = 1'b0;
        RdRam     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (Enable) state_d = S_EXEC;
            end
            S_EXEC: begin
                // Strobes only while actually executing; a stalled EXEC is idle
                if (Enable) begin
                    Addr = operand;
                    case (opcode)
                        OP_HLT:  stop = 1'b1;
                        OP_STO:  WrRam = 1'b1;
                        OP_LD: begin
                            RdRam = 1'b1;
                            WrAcc = 1'b1;
                        end
                        OP_LDI: begin
                            SelA  = 2'd1;
                            WrAcc = 1'b1;
                        end
                        OP_ADD: begin
                            RdRam = 1'b1;
                            SelA  = 2'd2;
                            WrAcc = 1'b1;
                        end
                        OP_ADDI: begin
                            SelB  = 1'b1;
                            SelA  = 2'd2;
                            WrAcc = 1'b1;
                        end
                        OP_SUB: begin
                            RdRam = 1'b1;
                            Op    = 1'b1;
                            SelA  = 2'd2;
                            WrAcc = 1'b1;
                        end
                        OP_SUBI: begin
                            SelB  = 1'b1;
                            Op    = 1'b1;
                            SelA  = 2'd2;
                            WrAcc = 1'b1;
                        end
                        default: begin
`ifdef BIP_ILLEGAL_TRAP_EN
                            stop      = 1'b1;
                            illegal_d = 1'b1;
`endif
                        end
                    endcase
                    if (stop) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = pc_q + PC_ONE;
                    end
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    assign Instr_Addr = pc_q;
    assign Halted     = (state_q == S_HALT);
`ifdef BIP_ILLEGAL_TRAP_EN
    assign Illegal    = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_bip_control_unit.sv
// Directed bench for bip_control_unit with a behavioural synchronous ROM.
// Drives at the falling edge and samples there, half a cycle after the active edge.
module tb_bip_control_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Enable;
    logic [10:0] Instr_Addr;
    logic [15:0] Instr;
    logic [1:0]  SelA;
    logic        SelB;
    logic [10:0] Addr;
    logic        WrAcc;
    logic        Op;
    logic        WrRam;
    logic        RdRam;
    logic        Halted;
`ifdef BIP_ILLEGAL_TRAP_EN
    logic        Illegal;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] rom [2048];

    bip_control_unit dut (
        .Clock(Clock),
        .Reset(Reset),
        .Enable(Enable),
        .Instr_Addr(Instr_Addr),
        .Instr(Instr),
        .SelA(SelA),
        .SelB(SelB),
        .Addr(Addr),
        .WrAcc(WrAcc),
        .Op(Op),
        .WrRam(WrRam),
        .RdRam(RdRam),
`ifdef BIP_ILLEGAL_TRAP_EN
        .Illegal(Illegal),
`endif
        .Halted(Halted)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) Instr <= rom[Instr_Addr];

    function automatic logic [15:0] ins(input int opc, input int opd);
        logic [4:0]  o;
        logic [10:0] d;
        o = 5'(opc);
        d = 11'(opd);
        return {o, d};
    endfunction

    // {SelA, SelB, Addr, WrAcc, Op, WrRam, RdRam, Halted}
    function automatic logic [31:0] ex(input int sa, input int sb, input int ad,
                                       input int wa, input int op, input int wr,
                                       input int rd, input int h);
        logic [18:0] v;
        v = {2'(sa), 1'(sb), 11'(ad), 1'(wa), 1'(op), 1'(wr), 1'(rd), 1'(h)};
        return {13'd0, v};
    endfunction

    function automatic logic [31:0] outs();
        return {13'd0, SelA, SelB, Addr, WrAcc, Op, WrRam, RdRam, Halted};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
        rom[0] = ins(3, 247);
        Reset  = 1'b1;
        Enable = 1'b1;

        // 1: reset
        tick();
        tick();
        Reset = 1'b0;
        chk("rst_pc", 32'(Instr_Addr), 32'd0);
        chk("rst_out", outs(), ex(0,0,0,0,0,0,0,0));
`ifdef BIP_ILLEGAL_TRAP_EN
        chk("rst_ill", 32'(Illegal), 32'd0);
`endif

        // 2: LDI 247
        tick();
        chk("ldi_exec", outs(), ex(1,0,247,1,0,0,0,0));
        chk("ldi_pc", 32'(Instr_Addr), 32'd0);
        tick();
        chk("ldi_done", outs(), ex(0,0,0,0,0,0,0,0));
        chk("ldi_pc1", 32'(Instr_Addr), 32'd1);

        // 3/4: new program, HLT at 4
        Reset = 1'b1;
        rom[0] = ins(2, 5);
        rom[1] = ins(5, 3);
        rom[2] = ins(6, 9);
        rom[3] = ins(1, 10);
        rom[4] = ins(0, 0);
        tick();
        Reset = 1'b0;
        chk("rst2_pc", 32'(Instr_Addr), 32'd0);
        tick();
        chk("ld_exec", outs(), ex(0,0,5,1,0,0,1,0));
        tick();
        chk("ld_fetch", outs(), ex(0,0,0,0,0,0,0,0));
        tick();
        chk("addi_exec", outs(), ex(2,1,3,1,0,0,0,0));
        tick();
        tick();
        chk("sub_exec", outs(), ex(2,0,9,1,1,0,1,0));
        tick();
        tick();
        chk("sto_exec", outs(), ex(0,0,10,0,0,1,0,0));
        chk("sto_pc", 32'(Instr_Addr), 32'd3);
        tick();
        chk("hlt_pc", 32'(Instr_Addr), 32'd4);
        tick();
        chk("hlt_exec", outs(), ex(0,0,0,0,0,0,0,0));
        for (int i = 0; i < 22; i++) begin
            tick();
            chk("halt_out", outs(), ex(0,0,0,0,0,0,0,1));
            chk("halt_pc", 32'(Instr_Addr), 32'd4);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("unhalt_pc", 32'(Instr_Addr), 32'd0);
        chk("unhalt_out", outs(), ex(0,0,0,0,0,0,0,0));

        // 5: stall in EXEC of LD 5
        tick();
        chk("stall_pre", outs(), ex(0,0,5,1,0,0,1,0));
        Enable = 1'b0;
        #1;
        chk("stall_idle0", outs(), ex(0,0,0,0,0,0,0,0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_idle", outs(), ex(0,0,0,0,0,0,0,0));
            chk("stall_pc", 32'(Instr_Addr), 32'd0);
        end
        Enable = 1'b1;
        #1;
        chk("stall_resume", outs(), ex(0,0,5,1,0,0,1,0));
        tick();
        chk("stall_pc1", 32'(Instr_Addr), 32'd1);
        chk("stall_after", outs(), ex(0,0,0,0,0,0,0,0));
        tick();
        chk("stall_next", outs(), ex(2,1,3,1,0,0,0,0));

        // 6: PC wrap, then opcode 11111
        Reset = 1'b1;
        for (int i = 0; i < 2048; i++) rom[i] = ins(3, i);
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 2047; i++) begin
            tick();
            tick();
            if (i == 0) rom[0] = ins(31, 0);
        end
        chk("wrap_pre", 32'(Instr_Addr), 32'd2047);
        tick();
        chk("wrap_exec", outs(), ex(1,0,2047,1,0,0,0,0));
        tick();
        chk("wrap_pc", 32'(Instr_Addr), 32'd0);
        tick();
        chk("ill_exec", outs(), ex(0,0,0,0,0,0,0,0));
        tick();
`ifdef BIP_ILLEGAL_TRAP_EN
        chk("ill_pc", 32'(Instr_Addr), 32'd0);
        chk("ill_halt", 32'(Halted), 32'd1);
        chk("ill_flag", 32'(Illegal), 32'd1);
        tick();
        tick();
        chk("ill_sticky", 32'(Illegal), 32'd1);
`else
        chk("nop_pc", 32'(Instr_Addr), 32'd1);
        chk("nop_halt", 32'(Halted), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
